// File: rtl/output_argmax.sv
// rtl/output_argmax.sv - streaming argmax over the output-layer register file
// Optional build macro ARGMAX_TIE_LAST_EN: ties resolve to the highest index instead of the lowest.
module output_argmax #(
  parameter int NUM_OUT = 10,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic signed [DATA_W-1:0] rd_data,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        class_idx,
  output logic signed [DATA_W-1:0] max_val
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_OUT - 1);

  logic [1:0]               r_state;
  logic [ADDR_W-1:0]        r_cnt;
  logic                     r_smp_vld;
  logic [ADDR_W-1:0]        r_smp_idx;
  logic signed [DATA_W-1:0] r_run_max;
  logic [ADDR_W-1:0]        r_run_idx;
  logic [ADDR_W-1:0]        r_class_idx;
  logic signed [DATA_W-1:0] r_max_val;

  logic                     w_first;
  logic                     w_better;
  logic                     w_take;
  logic signed [DATA_W-1:0] w_nxt_max;
  logic [ADDR_W-1:0]        w_nxt_idx;

  // rd_data belongs to the address issued one cycle earlier, tracked by r_smp_vld/r_smp_idx
  assign w_first = (r_smp_idx == '0);
`ifdef ARGMAX_TIE_LAST_EN
  assign w_better = (rd_data >= r_run_max);
`else
  assign w_better = (rd_data > r_run_max);
`endif
  assign w_take    = r_smp_vld && (w_first || w_better);
  assign w_nxt_max = w_take ? rd_data : r_run_max;
  assign w_nxt_idx = w_take ? r_smp_idx : r_run_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_smp_vld   <= 1'b0;
      r_smp_idx   <= '0;
      r_run_max   <= '0;
      r_run_idx   <= '0;
      r_class_idx <= '0;
      r_max_val   <= '0;
    end else begin
      r_smp_vld <= (r_state == S_SCAN);
      r_smp_idx <= r_cnt;
      r_run_max <= w_nxt_max;
      r_run_idx <= w_nxt_idx;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (start) r_state <= S_SCAN;
        end
        S_SCAN: begin
          if (r_cnt == LAST_ADDR) begin
            r_cnt   <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          // Final sample folds in here so the result is visible during FINISH
          r_class_idx <= w_nxt_idx;
          r_max_val   <= w_nxt_max;
          r_state     <= S_FINISH;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_en     = (r_state == S_SCAN);
  assign rd_addr   = rd_en ? r_cnt : '0;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FINISH);
  assign class_idx = r_class_idx;
  assign max_val   = r_max_val;

endmodule

// File: tb/tb_output_argmax.sv
// tb/tb_output_argmax.sv - directed scoreboard bench for output_argmax
module tb_output_argmax;
  localparam int NUM_OUT = 10;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 16;
`ifdef ARGMAX_TIE_LAST_EN
  localparam bit TIE_LAST = 1'b1;
`else
  localparam bit TIE_LAST = 1'b0;
`endif

  typedef struct {
    logic [ADDR_W-1:0]        idx;
    logic signed [DATA_W-1:0] val;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     start;
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic signed [DATA_W-1:0] rd_data;
  logic                     busy;
  logic                     done;
  logic [ADDR_W-1:0]        class_idx;
  logic signed [DATA_W-1:0] max_val;

  logic signed [DATA_W-1:0] mem [NUM_OUT];
  exp_t                     exp_q [$];
  int                       tests = 0;
  int                       fails = 0;
  logic [ADDR_W-1:0]        prev_idx;
  logic signed [DATA_W-1:0] prev_val;

  output_argmax #(.NUM_OUT(NUM_OUT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .done(done), .class_idx(class_idx), .max_val(max_val)
  );

  always #5 clk = ~clk;

  // Register file: one-cycle read latency; a large decoy value when no read was issued
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 16'sh7FFE;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model_argmax();
    exp_t e;
    e.idx = '0;
    e.val = mem[0];
    for (int i = 1; i < NUM_OUT; i++)
      if (mem[i] > e.val || (TIE_LAST && mem[i] == e.val)) begin
        e.idx = ADDR_W'(i);
        e.val = mem[i];
      end
    return e;
  endfunction

  // Starts one scan and checks every cycle T+1..T+NUM_OUT+4; rst_at>0 aborts with reset in cycle T+rst_at
  task automatic run_scan(input bit repulse, input int rst_at);
    exp_t e;
    exp_t got;
    bit   aborted;
    aborted = 1'b0;
    e = model_argmax();
    @(negedge clk);
    start = 1'b1;
    if (rst_at == 0) exp_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= NUM_OUT + 4; k++) begin
      @(negedge clk);
      if (aborted) begin
        check("abort_rd_en", 32'(rd_en), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_class_idx", 32'(class_idx), 32'(0));
        check("abort_max_val", 32'(max_val), 32'(0));
      end else begin
        check("rd_en", 32'(rd_en), 32'(k <= NUM_OUT));
        check("rd_addr", 32'(rd_addr), (k <= NUM_OUT) ? 32'(k - 1) : 32'(0));
        check("busy", 32'(busy), 32'(k <= NUM_OUT + 2));
        check("done", 32'(done), 32'(k == NUM_OUT + 2));
        if (done) begin
          check("scoreboard_nonempty", 32'(exp_q.size() > 0), 32'(1));
          if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            check("class_idx", 32'(class_idx), 32'(got.idx));
            check("max_val", 32'(max_val), 32'(got.val));
            prev_idx = got.idx;
            prev_val = got.val;
          end
        end else begin
          check("hold_class_idx", 32'(class_idx), 32'(prev_idx));
          check("hold_max_val", 32'(max_val), 32'(prev_val));
        end
      end
      start = repulse && (k == 4 || k == 8);
      if (rst_at != 0 && k == rst_at) reset = 1'b1;
      if (rst_at != 0 && k == rst_at + 1) reset = 1'b0;
      if (rst_at != 0 && k == rst_at) begin
        aborted  = 1'b1;
        prev_idx = '0;
        prev_val = '0;
      end
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    prev_idx = '0;
    prev_val = '0;
    for (int i = 0; i < NUM_OUT; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rd_en", 32'(rd_en), 32'(0));
    check("reset_rd_addr", 32'(rd_addr), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_class_idx", 32'(class_idx), 32'(0));
    check("reset_max_val", 32'(max_val), 32'(0));
    reset = 1'b0;

    // Mixed data: class 2, value 100
    mem = '{16'sd3, -16'sd5, 16'sd100, 16'sd7, 16'sd0, 16'sd1, 16'sd2, -16'sd1, 16'sd99, 16'sd4};
    run_scan(1'b0, 0);
    repeat (4) @(negedge clk);
    check("idle_hold_class_idx", 32'(class_idx), 32'(2));
    check("idle_hold_max_val", 32'(max_val), 32'(100));

    // All negative, most negative at index 0
    mem[0] = 16'sh8000;
    for (int i = 1; i < NUM_OUT; i++) mem[i] = DATA_W'(-200 + 20 * i);
    run_scan(1'b0, 0);
    check("neg_class_idx", 32'(prev_idx), 32'(9));

    // Tie at the positive limit
    for (int i = 0; i < NUM_OUT; i++) mem[i] = '0;
    mem[3] = 16'sh7FFF;
    mem[7] = 16'sh7FFF;
    run_scan(1'b0, 0);
    check("tie_class_idx", 32'(prev_idx), TIE_LAST ? 32'(7) : 32'(3));

    // Start re-pulsed while busy must be ignored
    mem = '{16'sd3, -16'sd5, 16'sd100, 16'sd7, 16'sd0, 16'sd1, 16'sd2, -16'sd1, 16'sd99, 16'sd4};
    run_scan(1'b1, 0);
    repeat (3) @(negedge clk);
    check("no_queued_scan_busy", 32'(busy), 32'(0));

    // Completed scan, aborted scan, then a normal scan
    run_scan(1'b0, 0);
    run_scan(1'b0, 5);
    run_scan(1'b0, 0);

    // Small-range random data to exercise ties
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NUM_OUT; i++) mem[i] = DATA_W'(int'($urandom_range(0, 6)) - 3);
      run_scan(1'b0, 0);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/output_argmax.md
OUTPUT_ARGMAX -- requirements
Module: output_argmax

Interface
REQ-001 SHALL have parameter NUM_OUT, default 10: number of output-layer results scanned (1..128).
REQ-002 SHALL have parameter ADDR_W, default 7: output register file address width.
REQ-003 SHALL have parameter DATA_W, default 16: signed result width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request to begin one scan; sampled in IDLE only.
REQ-007 SHALL have port rd_en  output  1  read strobe to the output register file.
REQ-008 SHALL have port rd_addr  output  ADDR_W  register file address for the current read.
REQ-009 SHALL have port rd_data  input  DATA_W  signed data for the address read one cycle earlier.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a scan completes.
REQ-012 SHALL have port class_idx  output  ADDR_W  index of the maximum result from the last completed scan.
REQ-013 SHALL have port max_val  output  DATA_W  signed maximum value from the last completed scan.

Function
REQ-014 SHALL implement FSM states IDLE, SCAN, DRAIN, FINISH.
REQ-015 IDLE: start=1 SHALL move to SCAN on the next edge, clearing the address counter to 0.
REQ-016 SCAN: rd_en SHALL be 1 and rd_addr SHALL equal the counter; the counter increments each cycle; after issuing address NUM_OUT-1 the FSM SHALL go to DRAIN.
REQ-017 DRAIN: rd_en SHALL be 0; the last returned sample SHALL be compared; the FSM then goes to FINISH.
REQ-018 FINISH: done SHALL be 1 for exactly one cycle, class_idx/max_val SHALL hold the new result from this cycle onward, and the FSM SHALL return to IDLE.
REQ-019 The read-data index SHALL equal the issued address delayed by one cycle; the sample for index 0 SHALL load the running maximum unconditionally.
REQ-020 Each later sample SHALL replace the running max and index when rd_data > running max (signed compare); equality SHALL keep the lower index.
REQ-021 With start sampled high at edge T, rd_en SHALL be high for cycles T+1..T+NUM_OUT and done SHALL be high in cycle T+NUM_OUT+2.
REQ-022 start while busy SHALL be ignored, with no restart, no extra reads and no queued scan.
REQ-023 class_idx/max_val SHALL change only in FINISH and SHALL hold between scans.
REQ-024 For NUM_OUT=1: a single read of address 0, result class_idx=0.
REQ-025 rd_addr SHALL be 0 whenever rd_en=0.

Reset
REQ-026 reset SHALL force IDLE and set rd_en=0, rd_addr=0, busy=0, done=0, class_idx=0, max_val=0, and clear the running max, index and counter.
REQ-027 reset during SCAN/DRAIN/FINISH SHALL abort the scan with no done pulse and no output update; reset overrides start in the same cycle.

Configuration
REQ-028 Macro ARGMAX_TIE_LAST_EN: when defined, equal values (>=) SHALL replace the running max, so ties resolve to the highest index; when undefined, strict > is used and ties resolve to the lowest index (REQ-020).

Verification
REQ-029 NUM_OUT=10, data [3,-5,100,7,0,1,2,-1,99,4], start at edge T -> rd_en high for exactly T+1..T+10; done in cycle T+12; class_idx=2; max_val=100.
REQ-030 All-negative data [-200,-180,...,-20] ascending, with 0x8000 at index 0 -> class_idx=9, max_val=-20 (signed-compare check).
REQ-031 0x7FFF at indices 3 and 7, other entries 0 -> class_idx=3 without ARGMAX_TIE_LAST_EN; class_idx=7 with it.
REQ-032 start re-pulsed at T+4 and T+8 during a scan -> one done pulse only, exactly 10 rd_en cycles; busy low again after FINISH.
REQ-033 Completed scan (class 2), then new scan with reset at T+5 -> IDLE next cycle, no done, class_idx=0, max_val=0; a subsequent start completes normally.
